seq_table_ctrl: RTL

//  Controller for a table-driven (ROM-style) state sequencer. Entries are indexed by {a,state}.

---
 rtl/seq_table_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_table_ctrl.sv
// Table-driven state sequencer: {a,state}-indexed next-state/output table with a config port.
// Define SEQCTRL_DEFAULT_TABLE_EN to preload the built-in sequence table at power-up.
module seq_table_ctrl #(
    parameter int SW = 3,
    parameter int OW = 3,
    parameter int CW = 8,
    parameter logic [SW-1:0] INIT_STATE = SW'(2),
    parameter logic [SW-1:0] HALT_STATE = SW'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [SW:0]      cfg_addr,
    input  logic [SW+OW-1:0] cfg_data,
    input  logic             start,
    input  logic             a_valid,
    input  logic             a,
    output logic             a_ready,
    output logic             y_valid,
    output logic [OW-1:0]    y,
    output logic [SW-1:0]    state,
    output logic [CW-1:0]    steps,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             cfg_err
);

    localparam int DEPTH = 2 ** (SW + 1);
    // Step count one below the limit; an accept here saturates the counter and ends the run.
    localparam logic [CW-1:0] STEP_PRE = {{(CW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_t;
    typedef logic [SW+OW-1:0] tbl_t [DEPTH];

`ifdef SEQCTRL_DEFAULT_TABLE_EN
    function automatic tbl_t default_table();
        tbl_t t;
        logic [SW-1:0] s, nx;
        logic ai;
        for (int i = 0; i < DEPTH; i++) begin
            s  = SW'(i);
            ai = i[SW];
            case (s)
                SW'(2):  nx = SW'(6);
                SW'(6):  nx = ai ? SW'(7) : SW'(5);
                SW'(5):  nx = SW'(4);
                SW'(4):  nx = ai ? SW'(6) : SW'(2);
                SW'(7):  nx = SW'(5);
                default: nx = SW'(2);
            endcase
            t[i] = {nx, OW'(nx)};
        end
        return t;
    endfunction

    tbl_t tbl = default_table();
`else
    tbl_t tbl;
`endif

    ctrl_t ctrl, ctrl_nx;
    logic accept, idle_or_done, ends_run;
    logic [SW+OW-1:0] entry;
    logic [SW-1:0] ent_next;
    logic [OW-1:0] ent_out;

    assign idle_or_done = (ctrl == IDLE) || (ctrl == DONE);
    assign a_ready      = (ctrl == RUN);
    assign busy         = (ctrl == RUN);
    assign done         = (ctrl == DONE);
    assign accept       = a_ready && a_valid;
    assign entry        = tbl[{a, state}];
    assign ent_next     = entry[SW+OW-1:OW];
    assign ent_out      = entry[OW-1:0];
    assign ends_run     = (ent_next == HALT_STATE) || (steps == STEP_PRE);

    always_comb begin
        ctrl_nx = ctrl;
        unique case (ctrl)
            IDLE:    if (start) ctrl_nx = RUN;
            RUN:     if (accept && ends_run) ctrl_nx = DONE;
            DONE:    if (start) ctrl_nx = RUN;
            default: ctrl_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl    <= IDLE;
            state   <= INIT_STATE;
            y       <= '0;
            y_valid <= 1'b0;
            steps   <= '0;
            ovf     <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            ctrl    <= ctrl_nx;
            y_valid <= accept;
            if (cfg_we && !idle_or_done)
                cfg_err <= 1'b1;
            if (idle_or_done && start) begin
                state <= INIT_STATE;
                steps <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                state <= ent_next;
                y     <= ent_out;
                steps <= steps + 1'b1;
                if (steps == STEP_PRE)
                    ovf <= 1'b1;
            end
        end
    end

    // Table storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we && idle_or_done)
            tbl[cfg_addr] <= cfg_data;
    end

endmodule
